d_mem: RTL and testbench
========================

# d_mem

Data-memory stage of the MIPS datapath, directly downstream of the ULA: it takes the ULA result as the effective address and executes loads and stores of byte, halfword or word size against an internal word array. Each access goes through a req/done handshake with a programmable number of wait states, so the surrounding control can stall the PC while an access is outstanding. Misaligned, out-of-range and reserved-size accesses are reported through a fault flag instead of being executed.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; valid word index 0..DEPTH_WORDS-1.
- WAIT_STATES, 2: extra cycles between acceptance and completion; range 0..15.
- clock  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (faults).
- unsigned_load  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- addr  in  32  byte address, driven from ula_result.
- wdata  in  32  store data (rt); the low byte or low halfword is used for sub-word sizes.
- rdata  out  32  load result, registered; valid while done=1 and held until the next completion.
- done  out  1  one-cycle completion pulse.
- fault  out  1  qualifies done; 1 = access rejected, with memory and rdata unchanged.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Byte order is little-endian. Byte k of a word is bits [8k+7:8k], and the word index is addr[31:2].
- An access faults when any of these holds:
  - size=11.
  - size=01 with addr[0]=1.
  - size=10 with addr[1:0]≠00.
  - addr[31:2] ≥ DEPTH_WORDS.
- FSM states are IDLE, WAIT, DONE and FAULT.
  - IDLE & req & fault condition → FAULT.
  - IDLE & req & legal access, with WAIT_STATES>0 → WAIT. The address, we, size, unsigned_load and wdata are latched, and the counter is loaded with WAIT_STATES-1.
  - IDLE & req & legal access, with WAIT_STATES=0 → DONE directly, with the same latching.
  - WAIT with counter≠0 → WAIT, and the counter decrements.
  - WAIT with counter=0 → DONE.
  - DONE → IDLE, and FAULT → IDLE, unconditionally.
- The memory operation happens on the edge that enters DONE:
  - A store updates only the addressed byte lanes.
  - A load writes the extended value into rdata.
- req while busy is ignored. It is not queued; the requester must hold req or re-assert it after done.
- Inputs other than req are don't-care outside the IDLE acceptance cycle, because the latched copies are used.
- Array contents are not cleared by reset and are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, rdata 0, done 0, fault 0, busy 0.
- With req accepted at edge k, done=1 in cycle k+WAIT_STATES+1, which is WAIT_STATES+1 cycles of latency.
- A fault is reported with done=fault=1 in cycle k+1, which is 1 cycle of latency regardless of WAIT_STATES.
- busy is high from cycle k+1 through the done cycle inclusive.
- The next request can be accepted at the edge that ends the done cycle only if the FSM is back in IDLE. Because DONE → IDLE takes one edge, the earliest acceptance is the edge after done, giving a throughput of one access per WAIT_STATES+2 cycles.
- Reset during WAIT aborts the access: no store is committed, rdata keeps its reset value 0, and no done pulse is produced.
- Reset in the same cycle as a DONE-entering edge takes priority: the store is not committed and rdata is cleared.
- Simultaneous req and reset: reset wins and the request is dropped.
- The counter wraps are unreachable, since the counter is loaded to at most 14.

## Structure
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - the state enum (IDLE, WAIT, DONE, FAULT).
  - the fault-check function.
- The natural sub-module is d_mem_lane. It is purely combinational and contains:
  - store-merge: old word + wdata + size + addr[1:0] → new word.
  - load-extract: word + size + addr[1:0] + unsigned_load → extended 32-bit result.
- The top level holds the FSM, the wait counter, the latched request registers, the word array and the rdata register. Expected size is about 180–250 lines in total.

## Test plan
- **Reset then word round-trip** (WAIT_STATES=2):
  - Stimulus: store word 0xDEADBEEF at 0x10; then load word from 0x10.
  - Required: done occurs 3 cycles after each accept; rdata=0xDEADBEEF; fault=0; busy high for exactly 3 cycles per access.
- **Byte lanes and extension**:
  - Stimulus: store byte 0x80 at 0x13, over the word from the previous scenario.
  - Required: the word reads 0x80ADBEEF; a signed byte load from 0x13 returns 0xFFFFFF80; an unsigned byte load returns 0x00000080; a halfword load from 0x12 returns 0xFFFF80AD.
- **Faults**:
  - Stimulus: halfword load at 0x11; word store at 0x12; size=11; addr=4·DEPTH_WORDS.
  - Required: each gives done=fault=1 exactly 1 cycle after accept; memory is unchanged; rdata holds its previous value.
- **Ignored requests**:
  - Stimulus: hold req high continuously with alternating addresses.
  - Required: a new access is accepted only in IDLE, with one completion every WAIT_STATES+2 cycles; requests raised during busy are not queued.
- **Reset mid-access**:
  - Stimulus: store 0x12345678 to 0x20, with reset asserted in the second WAIT cycle.
  - Required: no done pulse; all outputs return to 0; a later load from 0x20 returns the pre-store contents.
- **Zero wait states** (WAIT_STATES=0):
  - Stimulus: store then load of 0xCAFEF00D at 0x0.
  - Required: done 1 cycle after each accept; rdata=0xCAFEF00D.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings,
// the controller state type and the access legality check.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // True when the access must be rejected rather than executed.
  function automatic logic access_fault(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = ((size == SZ_HALF) && addr[0]) ||
                   ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= depth_words);
    return (size == SZ_RSVD) || misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/d_mem_lane.sv
// Byte-lane steering for the data memory: merges store data into the old
// word and extracts/extends load data. Purely combinational, little-endian.
module d_mem_lane
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  input  logic        unsigned_load,
  output logic [31:0] new_word,
  output logic [31:0] load_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Store merge: only the addressed lanes take new data.
  always_comb begin
    new_word = old_word;
    case (size)
      SZ_BYTE: new_word[{byte_off, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: new_word[{byte_off[1], 4'b0000} +: 16]   = wdata[15:0];
      SZ_WORD: new_word                                 = wdata;
      default: new_word                                 = old_word;
    endcase
  end

  // Load extract: pick the addressed lanes, then zero- or sign-extend.
  always_comb begin
    byte_val  = old_word[{byte_off, 3'b000} +: 8];
    half_val  = old_word[{byte_off[1], 4'b0000} +: 16];
    load_word = old_word;
    case (size)
      SZ_BYTE: load_word = unsigned_load ? {24'h0, byte_val}
                                         : {{24{byte_val[7]}}, byte_val};
      SZ_HALF: load_word = unsigned_load ? {16'h0, half_val}
                                         : {{16{half_val[15]}}, half_val};
      default: load_word = old_word;
    endcase
  end

endmodule

// File: rtl/d_mem.sv
// Data-memory stage: req/done handshake with programmable wait states,
// byte/half/word loads and stores against an internal word array, and
// fault reporting for misaligned, out-of-range and reserved-size accesses.
//
// state | meaning
// IDLE  | waiting for req; request fields are taken straight from the inputs
// WAIT  | access accepted, counting down wait states on latched fields
// DONE  | access committed on entry; done pulse, rdata valid
// FAULT | access rejected; done and fault pulse, nothing changed
module d_mem
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic        busy
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               in_idle;
  logic [IDX_W-1:0]   cur_idx;
  logic [1:0]         cur_off;
  logic               cur_we;
  logic [1:0]         cur_size;
  logic               cur_uns;
  logic [31:0]        cur_wdata;
  logic               req_fault;
  logic               enter_done;
  logic               mem_we;
  logic [31:0]        old_word;
  logic [31:0]        new_word;
  logic [31:0]        load_word;

  // With zero wait states DONE is entered on the accept edge, so the lanes
  // must see the live inputs in IDLE and the latched copies afterwards.
  always_comb begin
    in_idle   = (state_q == IDLE);
    cur_idx   = in_idle ? addr[IDX_W+1:2] : idx_q;
    cur_off   = in_idle ? addr[1:0]       : off_q;
    cur_we    = in_idle ? we              : we_q;
    cur_size  = in_idle ? size            : size_q;
    cur_uns   = in_idle ? unsigned_load   : uns_q;
    cur_wdata = in_idle ? wdata           : wdata_q;
    req_fault = access_fault(size, addr, DEPTH_WORDS);
    old_word  = mem_q[cur_idx];
  end

  d_mem_lane u_lane (
    .old_word      (old_word),
    .wdata         (cur_wdata),
    .size          (cur_size),
    .byte_off      (cur_off),
    .unsigned_load (cur_uns),
    .new_word      (new_word),
    .load_word     (load_word)
  );

  // Next-state, wait counter, request latching and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    off_d      = off_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_fault) begin
            state_d = FAULT;
          end else begin
            idx_d   = addr[IDX_W+1:2];
            off_d   = addr[1:0];
            we_d    = we;
            size_d  = size;
            uns_d   = unsigned_load;
            wdata_d = wdata;
            cnt_d   = CNT_LOAD;
            if (WAIT_STATES == 0) begin
              state_d    = DONE;
              enter_done = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = (enter_done && !cur_we) ? load_word : rdata_q;
    done_d  = (state_d == DONE) || (state_d == FAULT);
    fault_d = (state_d == FAULT);
    busy_d  = (state_d != IDLE);
    mem_we  = enter_done && cur_we && !reset;
  end

  // Control and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
    end
  end

  // Word array is not reset; a store commits on the edge entering DONE.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[cur_idx] <= new_word;
    end
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign fault = fault_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_d_mem.sv
// Self-checking bench for d_mem: instance A with two wait states, instance B
// with none, both checked against a byte-addressed reference model.
module tb_d_mem;

  localparam int DEPTH = 256;
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, req_a, req_b;
  logic        we_i, uns_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_a, rdata_b;
  logic        done_a, done_b, fault_a, fault_b, busy_a, busy_b;

  int          cur = 0;
  logic [31:0] o_rdata;
  logic        o_done, o_fault, o_busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  model [logic [32:0]];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  d_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) u_dut_a (
    .clock(clk), .reset(rst_a), .req(req_a), .we(we_i), .size(size_i),
    .unsigned_load(uns_i), .addr(addr_i), .wdata(wdata_i),
    .rdata(rdata_a), .done(done_a), .fault(fault_a), .busy(busy_a)
  );

  d_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) u_dut_b (
    .clock(clk), .reset(rst_b), .req(req_b), .we(we_i), .size(size_i),
    .unsigned_load(uns_i), .addr(addr_i), .wdata(wdata_i),
    .rdata(rdata_b), .done(done_b), .fault(fault_b), .busy(busy_b)
  );

  assign o_rdata = (cur == 0) ? rdata_a : rdata_b;
  assign o_done  = (cur == 0) ? done_a  : done_b;
  assign o_fault = (cur == 0) ? fault_a : fault_b;
  assign o_busy  = (cur == 0) ? busy_a  : busy_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic bit m_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || ((a / 4) >= DEPTH);
  endfunction

  function automatic int m_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input int s, input logic [1:0] sz,
                                         input bit u, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] mask;
    int nb;
    nb = m_bytes(sz);
    v  = 32'h0;
    for (int i = 0; i < nb; i++)
      v = v | (32'(model[{s[0], a + 32'(i)}]) << (8 * i));
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      if (!u && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic m_store(input int s, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < m_bytes(sz); i++) begin
      t = wd >> (8 * i);
      model[{s[0], a + 32'(i)}] = t[7:0];
    end
  endtask

  // One complete access on instance s; called and returns at a negedge.
  task automatic do_access(input int s, input bit w, input logic [1:0] sz, input bit u,
                           input logic [31:0] a, input logic [31:0] wd, input string tag);
    bit f;
    int lat_exp, n, nbusy;
    logic [31:0] exp_rd;
    f       = m_fault(sz, a);
    lat_exp = f ? 1 : (((s == 0) ? WS_A : WS_B) + 1);
    exp_rd  = (!f && !w) ? m_load(s, sz, u, a) : last_rd[s];
    cur     = s;
    we_i = w; size_i = sz; uns_i = u; addr_i = a; wdata_i = wd;
    if (s == 0) req_a = 1'b1; else req_b = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    // Scramble inputs: the DUT must work from its latched copies.
    we_i = ~w; size_i = 2'($urandom); uns_i = ~u; addr_i = $urandom; wdata_i = $urandom;
    n = 0; nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (o_busy) nbusy++;
    end while (!o_done && n < 40);
    chk({tag, "_lat"},   32'(n),     32'(lat_exp));
    chk({tag, "_fault"}, 32'(o_fault), 32'(f));
    chk({tag, "_busy"},  32'(nbusy), 32'(n));
    chk({tag, "_rdata"}, o_rdata,    exp_rd);
    if (!f && w) m_store(s, sz, a, wd);
    last_rd[s] = exp_rd;
    @(negedge clk);
    chk({tag, "_pulse"}, {30'h0, o_done, o_busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] expq [$];
    int last_done, ndone, seen, r;
    bit w;
    logic [1:0] sz;
    logic [31:0] a;

    rst_a = 1; rst_b = 1; req_a = 0; req_b = 0;
    we_i = 0; uns_i = 0; size_i = 0; addr_i = 0; wdata_i = 0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a", {rdata_a[31:3], done_a, fault_a, busy_a}, 32'h0);
    chk("rst_a_rdata", rdata_a, 32'h0);
    chk("rst_b", {rdata_b[31:3], done_b, fault_b, busy_b}, 32'h0);
    chk("rst_b_rdata", rdata_b, 32'h0);
    rst_a = 0; rst_b = 0;
    @(negedge clk);

    // Word round trip, byte lanes and extension on A.
    do_access(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, "st_word");
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, "ld_word");
    chk("rt_word", o_rdata, 32'hDEADBEEF);
    do_access(0, 1, 2'b00, 0, 32'h13, 32'h5555_5580, "st_byte");
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, "ld_merged");
    chk("merged", o_rdata, 32'h80ADBEEF);
    do_access(0, 0, 2'b00, 0, 32'h13, 32'h0, "ld_sbyte");
    chk("sbyte", o_rdata, 32'hFFFFFF80);
    do_access(0, 0, 2'b00, 1, 32'h13, 32'h0, "ld_ubyte");
    chk("ubyte", o_rdata, 32'h00000080);
    do_access(0, 0, 2'b01, 0, 32'h12, 32'h0, "ld_shalf");
    chk("shalf", o_rdata, 32'hFFFF80AD);

    // Faults: one-cycle latency, rdata held, memory unchanged.
    do_access(0, 0, 2'b01, 0, 32'h11, 32'h0, "f_half");
    do_access(0, 1, 2'b10, 0, 32'h12, 32'h11111111, "f_word");
    do_access(0, 1, 2'b11, 0, 32'h10, 32'h22222222, "f_rsvd");
    do_access(0, 0, 2'b10, 0, 32'(4 * DEPTH), 32'h0, "f_range");
    chk("f_held", o_rdata, 32'hFFFF80AD);
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, "f_after");
    chk("f_unchanged", o_rdata, 32'h80ADBEEF);

    do_access(0, 1, 2'b10, 0, 32'h14, 32'h01020304, "st_14");
    do_access(0, 1, 2'b10, 0, 32'h20, 32'h0BADF00D, "st_20");

    // Hold req high with alternating addresses: acceptance only in IDLE.
    cur = 0; we_i = 0; size_i = 2'b10; uns_i = 0;
    last_done = -1; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_done) begin
        chk("hold_fault", 32'(o_fault), 32'h0);
        if (expq.size() > 0) chk("hold_rdata", o_rdata, expq.pop_front());
        else chk("hold_unexpected_done", 32'h1, 32'h0);
        if (last_done >= 0) chk("hold_gap", 32'(c - last_done), 32'(WS_A + 2));
        last_done = c;
        ndone++;
      end
      addr_i = c[0] ? 32'h14 : 32'h10;
      req_a  = 1'b1;
      if (!o_busy) expq.push_back(m_load(0, 2'b10, 0, addr_i));
      @(negedge clk);
    end
    req_a = 1'b0;
    for (int c = 0; c < 10 && expq.size() > 0; c++) begin
      if (o_done) begin
        chk("hold_drain_rdata", o_rdata, expq.pop_front());
        ndone++;
      end
      @(negedge clk);
    end
    chk("hold_count", 32'(ndone), 32'd5);
    chk("hold_queue_empty", 32'(expq.size()), 32'h0);
    while (o_busy) @(negedge clk);
    last_rd[0] = o_rdata;

    // Reset during the second WAIT cycle aborts the store.
    cur = 0; we_i = 1; size_i = 2'b10; addr_i = 32'h20; wdata_i = 32'h12345678;
    req_a = 1'b1;
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    chk("rmid_busy", 32'(o_busy), 32'h1);
    @(posedge clk); #1 rst_a = 1'b1;
    @(posedge clk); #1 rst_a = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    chk("rmid_no_done", 32'(seen), 32'h0);
    chk("rmid_outs", {29'h0, o_done, o_fault, o_busy}, 32'h0);
    chk("rmid_rdata", o_rdata, 32'h0);
    last_rd[0] = 32'h0;
    do_access(0, 0, 2'b10, 0, 32'h20, 32'h0, "rmid_load");
    chk("rmid_old", o_rdata, 32'h0BADF00D);

    // Zero wait states on B.
    do_access(1, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, "z_st");
    do_access(1, 0, 2'b10, 0, 32'h0, 32'h0, "z_ld");
    chk("z_rdata", o_rdata, 32'hCAFEF00D);

    // Randomized traffic on both instances over a prefilled region.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        do_access(s, 1, 2'b10, 0, 32'h100 + 32'(4 * i), $urandom, "pre");
      for (int i = 0; i < 40; i++) begin
        w  = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        r  = $urandom_range(0, 9);
        if (r == 0)      a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
        else if (r == 1) a = $urandom | 32'h8000_0000;
        else             a = 32'h100 + 32'($urandom_range(0, 63));
        do_access(s, w, sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
